// File: rtl/frogger_pkg.sv
// Shared types and sprite/timing constants for the frog collision block.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_DYING     = 2'd1,
    ST_RESPAWN   = 2'd2,
    ST_GAME_OVER = 2'd3
  } frog_state_e;

  localparam int NUM_CARS     = 8;
  localparam int FROG_HALF    = 12;
  localparam int CAR_HALF_W   = 23;
  localparam int CAR_HALF_H   = 12;
  localparam int DEATH_FRAMES = 30;
  localparam int START_LIVES  = 3;
  localparam int CNT_W        = 16;

  function automatic logic signed [31:0] abs32(input logic signed [31:0] v);
    return (v < 32'sd0) ? -v : v;
  endfunction

endpackage

// File: rtl/car_overlap.sv
// Combinational signed box-overlap test between the frog and one car.
module car_overlap #(
  parameter int FROG_HALF  = frogger_pkg::FROG_HALF,
  parameter int CAR_HALF_W = frogger_pkg::CAR_HALF_W,
  parameter int CAR_HALF_H = frogger_pkg::CAR_HALF_H
) (
  input  logic signed [31:0] frog_x_i,
  input  logic signed [31:0] frog_y_i,
  input  logic signed [31:0] car_x_i,
  input  logic signed [31:0] car_y_i,
  output logic               overlap_o
);
  import frogger_pkg::*;

  localparam logic signed [31:0] LIM_X = 32'(FROG_HALF + CAR_HALF_W);
  localparam logic signed [31:0] LIM_Y = 32'(FROG_HALF + CAR_HALF_H);

  logic signed [31:0] dx_s;
  logic signed [31:0] dy_s;

  // Touching edges (distance equal to the limit) do not count as a hit.
  assign dx_s      = abs32(frog_x_i - car_x_i);
  assign dy_s      = abs32(frog_y_i - car_y_i);
  assign overlap_o = (dx_s < LIM_X) && (dy_s < LIM_Y);

endmodule

// File: rtl/frog_collision.sv
// Frog-vs-car collision detection with lives, death animation and respawn control.
module frog_collision #(
  parameter int NUM_CARS     = frogger_pkg::NUM_CARS,
  parameter int FROG_HALF    = frogger_pkg::FROG_HALF,
  parameter int CAR_HALF_W   = frogger_pkg::CAR_HALF_W,
  parameter int CAR_HALF_H   = frogger_pkg::CAR_HALF_H,
  parameter int DEATH_FRAMES = frogger_pkg::DEATH_FRAMES,
  parameter int START_LIVES  = frogger_pkg::START_LIVES
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               restart,
  input  logic signed [31:0] frog_x,
  input  logic signed [31:0] frog_y,
  input  logic signed [31:0] car_x [NUM_CARS],
  input  logic signed [31:0] car_y [NUM_CARS],
  output logic               hit,
  output logic [2:0]         hit_idx,
  output logic               dying,
  output logic               respawn,
  output logic               game_over,
  output logic [2:0]         lives
);
  import frogger_pkg::*;

  logic [NUM_CARS-1:0] overlap_s;
  logic                any_s;
  logic [2:0]          win_idx_s;

  frog_state_e         state_q, state_d;
  logic [2:0]          lives_q, lives_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hit_q, hit_d;
  logic [2:0]          hit_idx_q, hit_idx_d;
  logic                dying_q, respawn_q, game_over_q;

  for (genvar g = 0; g < NUM_CARS; g++) begin : g_car
    car_overlap #(
      .FROG_HALF  (FROG_HALF),
      .CAR_HALF_W (CAR_HALF_W),
      .CAR_HALF_H (CAR_HALF_H)
    ) u_overlap (
      .frog_x_i  (frog_x),
      .frog_y_i  (frog_y),
      .car_x_i   (car_x[g]),
      .car_y_i   (car_y[g]),
      .overlap_o (overlap_s[g])
    );
  end

  // Priority encoder: scanning downward lets the lowest overlapping index win.
  always_comb begin
    any_s     = |overlap_s;
    win_idx_s = 3'd0;
    for (int i = NUM_CARS - 1; i >= 0; i--) begin
      win_idx_s = overlap_s[i] ? 3'(i) : win_idx_s;
    end
  end

  // Next-state logic for the life cycle FSM, counter, lives and hit pulse.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    hit_idx_d = hit_idx_q;
    if (restart) begin
      state_d = ST_ALIVE;
      lives_d = 3'(START_LIVES);
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (any_s) begin
            state_d   = ST_DYING;
            hit_d     = 1'b1;
            hit_idx_d = win_idx_s;
            cnt_d     = CNT_W'(DEATH_FRAMES - 1);
            lives_d   = (lives_q != 3'd0) ? (lives_q - 3'd1) : 3'd0;
          end else begin
            state_d = ST_ALIVE;
          end
        end
        ST_DYING: begin
          if (cnt_q == '0) begin
            state_d = (lives_q == 3'd0) ? ST_GAME_OVER : ST_RESPAWN;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RESPAWN:   state_d = ST_ALIVE;
        ST_GAME_OVER: begin
          state_d = ST_GAME_OVER;
          lives_d = 3'd0;
        end
        default:      state_d = ST_ALIVE;
      endcase
    end
  end

  // State and output registers; status flags are decoded from the next state.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= ST_ALIVE;
      lives_q     <= 3'(START_LIVES);
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= 3'd0;
      dying_q     <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      hit_q       <= hit_d;
      hit_idx_q   <= hit_idx_d;
      dying_q     <= (state_d == ST_DYING);
      respawn_q   <= (state_d == ST_RESPAWN);
      game_over_q <= (state_d == ST_GAME_OVER);
    end
  end

  assign hit       = hit_q;
  assign hit_idx   = hit_idx_q;
  assign dying     = dying_q;
  assign respawn   = respawn_q;
  assign game_over = game_over_q;
  assign lives     = lives_q;

endmodule

// File: tb/tb_frog_collision.sv
// Scoreboard bench: the driver queues the expected per-frame outputs, a monitor checks them.
module tb_frog_collision;

  logic               frame_clk;
  logic               Reset;
  logic               restart;
  logic signed [31:0] frog_x, frog_y;
  logic signed [31:0] car_x [8];
  logic signed [31:0] car_y [8];
  logic               hit, dying, respawn, game_over;
  logic [2:0]         hit_idx, lives;

  typedef struct {
    string      name;
    logic       hit;
    logic [2:0] idx;
    logic       dying;
    logic       resp;
    logic       go;
    logic [2:0] lives;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  frog_collision dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .restart   (restart),
    .frog_x    (frog_x),
    .frog_y    (frog_y),
    .car_x     (car_x),
    .car_y     (car_y),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .dying     (dying),
    .respawn   (respawn),
    .game_over (game_over),
    .lives     (lives)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  // Monitor: the DUT presents a fresh output set after every frame edge.
  always @(posedge frame_clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_tests++;
      if ({hit, hit_idx, dying, respawn, game_over, lives} !==
          {mon_e.hit, mon_e.idx, mon_e.dying, mon_e.resp, mon_e.go, mon_e.lives}) begin
        n_fail++;
        $display("FAIL %s: got hit=%0b idx=%0d dying=%0b respawn=%0b game_over=%0b lives=%0d, want hit=%0b idx=%0d dying=%0b respawn=%0b game_over=%0b lives=%0d",
                 mon_e.name, hit, hit_idx, dying, respawn, game_over, lives,
                 mon_e.hit, mon_e.idx, mon_e.dying, mon_e.resp, mon_e.go, mon_e.lives);
      end
    end
  end

  task automatic park();
    for (int i = 0; i < 8; i++) begin
      car_x[i] = 32'sd0;
      car_y[i] = 32'sd1000;
    end
    frog_x = 32'sd100;
    frog_y = 32'sd288;
  endtask

  task automatic step(input string nm, input logic rst, input logic rs, input logic h,
                      input logic [2:0] idx, input logic dy, input logic rp,
                      input logic go, input logic [2:0] lv);
    exp_t e;
    Reset   = rst;
    restart = rs;
    e.name = nm; e.hit = h; e.idx = idx; e.dying = dy; e.resp = rp; e.go = go; e.lives = lv;
    exp_q.push_back(e);
    @(negedge frame_clk);
  endtask

  task automatic dying_run(input string nm, input int n, input logic [2:0] idx, input logic [2:0] lv);
    repeat (n) step(nm, 1'b0, 1'b0, 1'b0, idx, 1'b1, 1'b0, 1'b0, lv);
  endtask

  // After a hit frame: 29 more dying frames, one respawn frame, then clear road and ALIVE.
  task automatic recover(input string nm, input logic [2:0] idx, input logic [2:0] lv);
    dying_run({nm, "_dying"}, 29, idx, lv);
    step({nm, "_respawn"}, 1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b1, 1'b0, lv);
    park();
    step({nm, "_alive"}, 1'b0, 1'b0, 1'b0, idx, 1'b0, 1'b0, 1'b0, lv);
  endtask

  initial begin
    Reset   = 1'b1;
    restart = 1'b0;
    park();
    @(negedge frame_clk);

    step("reset_a", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    step("reset_b", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    step("idle",    1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Single car hit, overlap held through the death animation.
    car_x[3] = 32'sd130; car_y[3] = 32'sd288;
    step("s1_hit", 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 3'd2);
    recover("s1", 3'd3, 3'd2);

    // Exact edge contact is not a hit; one pixel closer is.
    car_x[0] = 32'sd135; car_y[0] = 32'sd288;
    step("s2_edge_a", 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd2);
    step("s2_edge_b", 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 3'd2);
    car_x[0] = 32'sd134;
    step("s2_hit", 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd1);
    recover("s2", 3'd0, 3'd1);
    step("restart_1", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Two simultaneous overlaps: lowest index wins, single decrement.
    car_x[2] = 32'sd90;  car_y[2] = 32'sd300;
    car_x[5] = 32'sd110; car_y[5] = 32'sd280;
    step("s3_hit", 1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd2);
    recover("s3", 3'd2, 3'd2);
    step("restart_2", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 3'd3);

    // Three deaths in a row ending in game over, then restart.
    car_x[1] = 32'sd100; car_y[1] = 32'sd288;
    step("s4_hit1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 3'd2);
    recover("s4a", 3'd1, 3'd2);
    car_x[4] = 32'sd100; car_y[4] = 32'sd288;
    step("s4_hit2", 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 3'd1);
    recover("s4b", 3'd4, 3'd1);
    car_x[7] = 32'sd100; car_y[7] = 32'sd288;
    step("s4_hit3", 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 3'd0);
    dying_run("s4c_dying", 29, 3'd7, 3'd0);
    repeat (3) step("s4_game_over", 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b1, 3'd0);
    park();
    step("s4_restart", 1'b0, 1'b1, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 3'd3);
    step("s4_alive",   1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0, 1'b0, 3'd3);

    // Reset beats restart and an overlap on the same edge.
    car_x[1] = 32'sd100; car_y[1] = 32'sd288;
    step("rst_priority", 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    park();
    step("rst_prio_alive", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);

    // Negative coordinates need a signed compare; overlap held while dying.
    frog_x = -32'sd5;
    car_x[6] = -32'sd16; car_y[6] = 32'sd288;
    step("s5_hit", 1'b0, 1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b0, 3'd2);
    recover("s5", 3'd6, 3'd2);
    frog_x = 32'sd10;
    car_x[0] = -32'sd100; car_y[0] = 32'sd288;
    step("s5_far_neg", 1'b0, 1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b0, 3'd2);
    park();

    // Reset during the tenth dying frame aborts the animation without respawn.
    car_x[0] = 32'sd100; car_y[0] = 32'sd288;
    step("s6_hit", 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd1);
    dying_run("s6_dying", 9, 3'd0, 3'd1);
    step("s6_reset", 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);
    park();
    repeat (3) step("s6_after", 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3);

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected frames left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
